// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: data bus access, load/store lane formatting, writeback registers
module memory_access #(
  parameter int XLEN  = 32,
  parameter int OPLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memory,
  input  logic             mem_read_em,
  input  logic             mem_write_em,
  input  logic [1:0]       mem_size_em,
  input  logic             mem_unsigned_em,
  input  logic [XLEN-1:0]  store_data_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic             jump_state_em,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  curr_pc_em,
  input  logic [XLEN-1:0]  csr_out_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ack,
  output logic             jump_state_mw,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  curr_pc_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  csr_out_mw,
  output logic [XLEN-1:0]  mem_out_mw,
  output logic             misaligned_mw,
  output logic             stall_memory
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state;
  logic       mem_op;
  logic       misaligned;
  logic       access;
  logic       capture;
  logic [XLEN-1:0] wdata_fmt;
  logic [3:0]      be_fmt;
  logic [XLEN-1:0] load_fmt;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Access attributes latched at request time so load formatting does not
  // depend on execute inputs that may change once phase_memory drops.
  logic       load_q;
  logic [1:0] size_q;
  logic [1:0] lo_q;
  logic       uns_q;

  // Classify the current execute instruction and derive the stall/capture strobes
  always_comb begin
    mem_op       = phase_memory & (mem_read_em | mem_write_em);
    misaligned   = ((mem_size_em == 2'b01) & alu_out_em[0]) |
                   (mem_size_em[1] & (alu_out_em[1:0] != 2'b00));
    access       = mem_op & ~misaligned;
    stall_memory = access & (state != DONE);
    capture      = phase_memory & ~stall_memory;
  end

  // Store lane replication and byte enables; size 11 falls into the word case
  always_comb begin
    wdata_fmt = store_data_em;
    be_fmt    = 4'b1111;
    case (mem_size_em)
      2'b00: begin
        wdata_fmt = {(XLEN/8){store_data_em[7:0]}};
        be_fmt    = 4'b0001 << alu_out_em[1:0];
      end
      2'b01: begin
        wdata_fmt = {(XLEN/16){store_data_em[15:0]}};
        be_fmt    = alu_out_em[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension from the latched access attributes
  always_comb begin
    byte_sel = dmem_rdata[{lo_q, 3'b000} +: 8];
    half_sel = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_fmt = dmem_rdata;
    case (size_q)
      2'b00:   load_fmt = uns_q ? {{(XLEN-8){1'b0}}, byte_sel}
                                : {{(XLEN-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = uns_q ? {{(XLEN-16){1'b0}}, half_sel}
                                : {{(XLEN-16){half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  // Bus handshake FSM; also owns mem_out_mw since the ack edge and the capture edge both write it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_q     <= 1'b0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      uns_q      <= 1'b0;
      mem_out_mw <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_em;
            dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
            dmem_wdata <= wdata_fmt;
            dmem_be    <= be_fmt;
            load_q     <= ~mem_write_em;
            size_q     <= mem_size_em;
            lo_q       <= alu_out_em[1:0];
            uns_q      <= mem_unsigned_em;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            if (load_q) mem_out_mw <= load_fmt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A completed load keeps the data fetched on the ack edge; every other capture clears it
      if (capture && !(state == DONE && load_q)) mem_out_mw <= '0;
    end
  end

  // Pass-through registers toward writeback, updated only on non-stalled memory-phase cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_state_mw <= 1'b0;
      decoded_op_mw <= '0;
      rdsel_mw      <= 5'd0;
      curr_pc_mw    <= '0;
      alu_out_mw    <= '0;
      csr_out_mw    <= '0;
      misaligned_mw <= 1'b0;
    end else if (capture) begin
      jump_state_mw <= jump_state_em;
      decoded_op_mw <= decoded_op_em;
      rdsel_mw      <= rdsel_em;
      curr_pc_mw    <= curr_pc_em;
      alu_out_mw    <= alu_out_em;
      csr_out_mw    <= csr_out_em;
      misaligned_mw <= mem_op & misaligned;
    end
  end

endmodule
